// File: rtl/serial_tx.sv
// Serial transmitter: start bit, DATA_WIDTH data bits LSB first, optional even
// parity bit, stop bit. Each bit is held on Q for CLKS_PER_BIT clock cycles.
// A word is accepted only in IDLE, so input activity during a frame is ignored.
module serial_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 0
) (
    input  logic                  Clock,
    input  logic                  Resetn,
    input  logic [DATA_WIDTH-1:0] Data,
    input  logic                  Valid,
    output logic                  Ready,
    output logic                  Q,
    output logic                  Busy
);

    localparam int                IDX_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [15:0]       CNT_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state, state_nx;
    logic [15:0]           cnt, cnt_nx;
    logic [IDX_W-1:0]      idx, idx_nx;
    logic [DATA_WIDTH-1:0] shreg, shreg_nx;
    logic                  par, par_nx;
    logic                  q, q_nx;
    logic [DATA_WIDTH-1:0] sh_shift;
    logic                  bit_end;

    assign sh_shift = shreg >> 1;
    assign bit_end  = (cnt == CNT_LAST);
    assign Ready    = (state == IDLE);
    assign Busy     = (state != IDLE);
    assign Q        = q;

    // State, counters, shift register and the registered line value
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
            par   <= 1'b0;
            q     <= 1'b1;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            idx   <= idx_nx;
            shreg <= shreg_nx;
            par   <= par_nx;
            q     <= q_nx;
        end
    end

    // Next-state logic; q_nx is the value Q takes in the following cycle
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        idx_nx   = idx;
        shreg_nx = shreg;
        par_nx   = par;
        q_nx     = q;
        case (state)
            IDLE: begin
                q_nx = 1'b1;
                if (Valid) begin
                    state_nx = START;
                    shreg_nx = Data;
                    par_nx   = ^Data;
                    cnt_nx   = '0;
                    idx_nx   = '0;
                    q_nx     = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_nx = DATA;
                    cnt_nx   = '0;
                    q_nx     = shreg[0];
                end else begin
                    cnt_nx = cnt + 16'd1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_nx = '0;
                    if (idx == IDX_LAST) begin
                        idx_nx = '0;
                        if (PARITY_EN != 0) begin
                            state_nx = PARITY;
                            q_nx     = par;
                        end else begin
                            state_nx = STOP;
                            q_nx     = 1'b1;
                        end
                    end else begin
                        idx_nx   = idx + IDX_W'(1);
                        shreg_nx = sh_shift;
                        q_nx     = sh_shift[0];
                    end
                end else begin
                    cnt_nx = cnt + 16'd1;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_nx = STOP;
                    cnt_nx   = '0;
                    q_nx     = 1'b1;
                end else begin
                    cnt_nx = cnt + 16'd1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                    q_nx     = 1'b1;
                end else begin
                    cnt_nx = cnt + 16'd1;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
                idx_nx   = '0;
                q_nx     = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: three instances (plain, parity, parity with one-cycle
// bits) share one stimulus stream. Each accepted word is predicted from the
// frame-length rule and queued; a monitor checks Q cycle by cycle against the
// frame bit sequence built from that word.
module tb_serial_tx;

    localparam int NI = 3;
    localparam int CPB [NI] = '{4, 4, 1};
    localparam int PE  [NI] = '{0, 1, 1};

    typedef struct {
        logic [7:0] d;
        int         t;
    } exp_t;

    logic       Clock;
    logic       Resetn;
    logic [7:0] Data;
    logic       Valid;
    logic [NI-1:0] q_o, rdy_o, bsy_o;

    exp_t q0[$], q1[$], q2[$];
    int   tick;
    bit   done;
    int   vectors, miscompares;

    serial_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) u_tx0 (
        .Clock(Clock), .Resetn(Resetn), .Data(Data), .Valid(Valid),
        .Ready(rdy_o[0]), .Q(q_o[0]), .Busy(bsy_o[0]));
    serial_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) u_tx1 (
        .Clock(Clock), .Resetn(Resetn), .Data(Data), .Valid(Valid),
        .Ready(rdy_o[1]), .Q(q_o[1]), .Busy(bsy_o[1]));
    serial_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(1), .PARITY_EN(1)) u_tx2 (
        .Clock(Clock), .Resetn(Resetn), .Data(Data), .Valid(Valid),
        .Ready(rdy_o[2]), .Q(q_o[2]), .Busy(bsy_o[2]));

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic int frame_len(int i);
        return (2 + 8 + PE[i]) * CPB[i];
    endfunction

    // Bit k of the frame: start, data LSB first, optional even parity, stop
    function automatic logic frame_bit(logic [7:0] d, int pe, int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if (k == 9 && pe != 0) return ^d;
        return 1'b1;
    endfunction

    task automatic push_e(int i, exp_t e);
        case (i)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    function automatic int qsize(int i);
        case (i)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t pop_e(int i);
        case (i)
            0: return q0.pop_front();
            1: return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    // ---------------- stimulus + acceptance model ----------------
    int rem [NI];

    task automatic cyc(input logic v, input logic [7:0] d);
        exp_t e;
        Valid = v;
        Data  = d;
        @(posedge Clock);
        tick++;
        for (int i = 0; i < NI; i++) begin
            if (!Resetn) rem[i] = 0;
            else if (rem[i] == 0 && Valid) begin
                e.d = Data;
                e.t = tick;
                push_e(i, e);
                rem[i] = frame_len(i);
            end else if (rem[i] > 0) rem[i]--;
        end
        #1;
    endtask

    task automatic do_reset(input int n);
        #1;
        Resetn = 1'b0;
        q0.delete();
        q1.delete();
        q2.delete();
        for (int k = 0; k < n; k++) cyc(1'b1, 8'($urandom));
        Resetn = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 8'($urandom));
    endtask

    initial begin
        tick   = 0;
        done   = 1'b0;
        Resetn = 1'b0;
        Valid  = 1'b0;
        Data   = 8'h00;
        for (int i = 0; i < NI; i++) rem[i] = 0;
        cyc(1'b0, 8'h00);
        cyc(1'b1, 8'h11);
        Resetn = 1'b1;
        // single frame
        cyc(1'b1, 8'hA5);
        idle(50);
        // parity pattern
        cyc(1'b1, 8'h07);
        idle(50);
        // back-to-back with Valid held
        cyc(1'b1, 8'h00);
        for (int k = 0; k < 100; k++) cyc(1'b1, 8'hFF);
        idle(50);
        // abort during data bit 3, then first-edge accept after release
        cyc(1'b1, 8'h3C);
        idle(17);
        do_reset(2);
        cyc(1'b1, 8'h81);
        idle(50);
        // ignore while busy
        cyc(1'b1, 8'h5A);
        for (int k = 0; k < 38; k++) cyc(k[0], 8'($urandom));
        idle(50);
        // random traffic with occasional resets
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 599) == 0) do_reset($urandom_range(1, 4));
            else if ($urandom_range(0, 9) < 7) cyc($urandom_range(0, 3) == 0, 8'($urandom));
            else cyc(1'b1, 8'($urandom));
        end
        idle(60);
        done = 1'b1;
        idle(4);
    end

    // ---------------- monitor / scoreboard ----------------
    task automatic chk(input string nm, input int i, input logic [2:0] act, input logic [2:0] exv);
        vectors++;
        if (act !== exv) begin
            miscompares++;
            $display("FAIL %s inst%0d tick%0d: q/ready/busy=%b expected %b", nm, i, tick, act, exv);
        end
    endtask

    task automatic chk_int(input string nm, input int i, input int act, input int exv);
        vectors++;
        if (act != exv) begin
            miscompares++;
            $display("FAIL %s inst%0d tick%0d: got %0d expected %0d", nm, i, tick, act, exv);
        end
    endtask

    bit         inf [NI];
    bit         gap [NI];
    int         pos [NI];
    logic [7:0] cur [NI];

    initial begin
        exp_t e;
        logic b;
        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < NI; i++) begin
            inf[i] = 1'b0;
            gap[i] = 1'b0;
            pos[i] = 0;
            cur[i] = 8'h00;
        end
        forever begin
            @(negedge Clock or negedge Resetn);
            #1;
            if (done) begin
                for (int i = 0; i < NI; i++) begin
                    chk_int("leftover_words", i, qsize(i), 0);
                    chk_int("open_frame", i, int'(inf[i]), 0);
                end
                $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
                $finish;
            end
            for (int i = 0; i < NI; i++) begin
                if (!Resetn) begin
                    chk("reset_state", i, {q_o[i], rdy_o[i], bsy_o[i]}, 3'b110);
                    inf[i] = 1'b0;
                    gap[i] = 1'b0;
                end else if (!inf[i]) begin
                    if (bsy_o[i]) begin
                        if (gap[i]) chk("idle_gap", i, {q_o[i], rdy_o[i], bsy_o[i]}, 3'b110);
                        gap[i] = 1'b0;
                        if (qsize(i) == 0) begin
                            chk_int("extra_frame", i, 1, 0);
                        end else begin
                            e = pop_e(i);
                            chk_int("start_tick", i, tick, e.t);
                            cur[i] = e.d;
                            inf[i] = 1'b1;
                            pos[i] = 0;
                        end
                    end else begin
                        chk("idle_line", i, {q_o[i], rdy_o[i], bsy_o[i]}, 3'b110);
                        gap[i] = 1'b0;
                    end
                end
                if (Resetn && inf[i]) begin
                    b = frame_bit(cur[i], PE[i], pos[i] / CPB[i]);
                    chk($sformatf("frame_%02h_bit%0d", cur[i], pos[i] / CPB[i]), i,
                        {q_o[i], rdy_o[i], bsy_o[i]}, {b, 1'b0, 1'b1});
                    pos[i]++;
                    if (pos[i] == frame_len(i)) begin
                        inf[i] = 1'b0;
                        gap[i] = 1'b1;
                    end
                end
            end
        end
    end

endmodule
